// File: rtl/int_ctrl.sv
// Vectored interrupt controller: four asynchronous level inputs, edge-latched
// pending bits, fixed priority (irq[0] highest), a mask register, nested
// in-service tracking, and a two-state IDLE/REQ handshake with the control unit.
module int_ctrl #(
    parameter logic [7:0] VEC_BASE = 8'hF0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] irq,
    input  logic       mask_we,
    input  logic [3:0] mask_in,
    input  logic       int_ack,
    input  logic       int_ret,
    output logic       int_req,
    output logic [7:0] int_vec,
    output logic [3:0] pending,
    output logic [3:0] in_service,
    output logic [3:0] mask
);

    localparam logic S_IDLE = 1'b0;
    localparam logic S_REQ  = 1'b1;

    logic [3:0] r_sync1;
    logic [3:0] r_sync2;
    logic [3:0] r_sync_prev;
    logic [1:0] r_warm;
    logic       r_state;
    logic [1:0] r_grant;
    logic [3:0] r_pending;
    logic [3:0] r_in_service;
    logic [3:0] r_mask;

    logic [3:0] w_rise;
    logic [3:0] w_elig;
    logic       w_any;
    logic [1:0] w_sel;
    logic       w_ack;
    logic [3:0] w_grant_bit;
    logic [3:0] w_ret_clr;

    // Synchronize the asynchronous lines and keep one cycle of history for edge detection.
    // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1     <= 4'h0;
            r_sync2     <= 4'h0;
            r_sync_prev <= 4'h0;
        end else begin
            r_sync1     <= irq;
            r_sync2     <= r_sync1;
            r_sync_prev <= r_sync2;
        end
    end

    // Blank edge detection until the synchronizer and history hold real samples,
    // so a line already high at reset release is not mistaken for a fresh edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_warm <= 2'd0;
        end else if (r_warm != 2'd3) begin
            r_warm <= r_warm + 2'd1;
        end
    end

    assign w_rise = r_sync2 & ~r_sync_prev & {4{r_warm == 2'd3}};

    // A source is eligible when pending, unmasked, and no equal-or-higher-priority handler is active.
    // NOTE: outputs of combinational blocks get a default first so no path infers a latch.
    always_comb begin
        logic v_blocked;
        w_elig    = 4'h0;
        v_blocked = 1'b0;
        for (int n = 0; n < 4; n++) begin
            v_blocked = v_blocked | r_in_service[n];
            w_elig[n] = r_pending[n] & r_mask[n] & ~v_blocked;
        end
    end

    // Fixed-priority encoder: lowest eligible index wins.
    always_comb begin
        w_sel = 2'd0;
        for (int n = 3; n >= 0; n--) begin
            if (w_elig[n]) begin
                w_sel = 2'(n);
            end
        end
    end

    assign w_any       = |w_elig;
    assign w_ack       = (r_state == S_REQ) && int_ack;
    assign w_grant_bit = 4'b0001 << r_grant;
    // Lowest set bit of in_service is the innermost (highest-priority) active handler.
    assign w_ret_clr   = int_ret ? (r_in_service & (~r_in_service + 4'd1)) : 4'h0;

    // Request handshake: latch the winner on entry, hold it unchanged until acknowledged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_grant <= 2'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_state <= S_REQ;
                        r_grant <= w_sel;
                    end
                end
                S_REQ: begin
                    if (int_ack) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Pending: acknowledged bit clears, but a coincident new edge re-sets it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pending <= 4'h0;
        end else begin
            r_pending <= (r_pending & ~(w_ack ? w_grant_bit : 4'h0)) | w_rise;
        end
    end

    // In-service: return retires the old innermost handler, then an ack adds the granted one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_in_service <= 4'h0;
        end else begin
            r_in_service <= (r_in_service & ~w_ret_clr) | (w_ack ? w_grant_bit : 4'h0);
        end
    end

    // Mask register write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mask <= 4'h0;
        end else if (mask_we) begin
            r_mask <= mask_in;
        end
    end

    // Outputs decode straight from state so reset drops the request without a clock.
    assign int_req    = (r_state == S_REQ);
    assign int_vec    = int_req ? (VEC_BASE + {4'h0, r_grant, 2'b00}) : VEC_BASE;
    assign pending    = r_pending;
    assign in_service = r_in_service;
    assign mask       = r_mask;

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: expected handler addresses are queued when
// an interrupt source is raised and compared when the request appears.
module tb_int_ctrl;

    logic       clk;
    logic       reset;
    logic [3:0] irq;
    logic       mask_we;
    logic [3:0] mask_in;
    logic       int_ack;
    logic       int_ret;
    logic       int_req;
    logic [7:0] int_vec;
    logic [3:0] pending;
    logic [3:0] in_service;
    logic [3:0] mask;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];

    int_ctrl #(.VEC_BASE(8'hF0)) dut (
        .clk        (clk),
        .reset      (reset),
        .irq        (irq),
        .mask_we    (mask_we),
        .mask_in    (mask_in),
        .int_ack    (int_ack),
        .int_ret    (int_ret),
        .int_req    (int_req),
        .int_vec    (int_vec),
        .pending    (pending),
        .in_service (in_service),
        .mask       (mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mask(input logic [3:0] m);
        mask_we = 1'b1;
        mask_in = m;
        tick();
        mask_we = 1'b0;
    endtask

    task automatic pulse_ack();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
    endtask

    task automatic pulse_ret();
        int_ret = 1'b1;
        tick();
        int_ret = 1'b0;
    endtask

    // Wait (bounded) for a request, then pop the scoreboard and compare the vector.
    task automatic wait_req(input string tag);
        int cyc = 0;
        logic [7:0] e;
        while (!int_req && cyc < 30) begin
            tick();
            cyc++;
        end
        check({tag, "_req"}, {31'b0, int_req}, 32'd1);
        if (int_req) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            check({tag, "_vec"}, {24'b0, int_vec}, {24'b0, e});
        end
    endtask

    initial begin
        reset   = 1'b0;
        irq     = 4'h0;
        mask_we = 1'b0;
        mask_in = 4'h0;
        int_ack = 1'b0;
        int_ret = 1'b0;
        repeat (3) tick();
        check("rst_req",  {31'b0, int_req}, 32'd0);
        check("rst_vec",  {24'b0, int_vec}, 32'hF0);
        check("rst_pend", {28'b0, pending}, 32'h0);
        check("rst_isr",  {28'b0, in_service}, 32'h0);
        check("rst_mask", {28'b0, mask}, 32'h0);
        reset = 1'b1;
        repeat (5) tick();

        // Basic: irq[2], 3-cycle latency, vector F8, ack clears pending.
        set_mask(4'hF);
        check("mask_wr", {28'b0, mask}, 32'hF);
        irq = 4'b0100;
        exp_q.push_back(8'hF8);
        tick(); tick();
        check("lat_2clk", {28'b0, pending}, 32'h0);
        tick();
        check("lat_3clk", {28'b0, pending}, 32'h4);
        irq = 4'h0;
        wait_req("basic");
        pulse_ack();
        check("basic_pend", {28'b0, pending}, 32'h0);
        check("basic_isr",  {28'b0, in_service}, 32'h4);
        check("basic_req",  {31'b0, int_req}, 32'd0);
        pulse_ret();
        check("basic_ret", {28'b0, in_service}, 32'h0);

        // Priority: irq[3] and irq[1] together.
        irq = 4'b1010;
        exp_q.push_back(8'hF4);
        exp_q.push_back(8'hFC);
        wait_req("prio1");
        pulse_ack();
        irq = 4'h0;
        check("prio_isr", {28'b0, in_service}, 32'h2);
        check("prio_pend", {28'b0, pending}, 32'h8);
        repeat (4) tick();
        check("prio_block", {31'b0, int_req}, 32'd0);
        pulse_ret();
        wait_req("prio3");
        pulse_ack();
        check("prio_isr3", {28'b0, in_service}, 32'h8);

        // Nesting: irq[0] preempts active handler 3.
        irq = 4'b0001;
        exp_q.push_back(8'hF0);
        wait_req("nest");
        pulse_ack();
        irq = 4'h0;
        check("nest_isr", {28'b0, in_service}, 32'h9);
        pulse_ret();
        check("nest_ret1", {28'b0, in_service}, 32'h8);
        pulse_ret();
        check("nest_ret2", {28'b0, in_service}, 32'h0);

        // Mask: masked source still latches pending, request follows the mask write.
        set_mask(4'h0);
        irq = 4'b0010;
        repeat (5) tick();
        check("mask_pend", {28'b0, pending}, 32'h2);
        check("mask_noreq", {31'b0, int_req}, 32'd0);
        exp_q.push_back(8'hF4);
        set_mask(4'h2);
        check("mask_same", {31'b0, int_req}, 32'd0);
        tick();
        check("mask_next", {31'b0, int_req}, 32'd1);
        wait_req("mask");
        pulse_ack();
        irq = 4'h0;
        pulse_ret();
        set_mask(4'hF);

        // Set wins over ack-clear for the granted source.
        irq = 4'b0100;
        exp_q.push_back(8'hF8);
        wait_req("setwin");
        irq = 4'h0;
        repeat (5) tick();
        irq = 4'b0100;
        tick(); tick();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        check("setwin_pend", {28'b0, pending}, 32'h4);
        check("setwin_isr",  {28'b0, in_service}, 32'h4);
        irq = 4'h0;
        tick(); tick();
        check("setwin_blk", {31'b0, int_req}, 32'd0);

        // Same-cycle ack and ret: ret retires old handler 2, then 0 is added.
        irq = 4'b0001;
        exp_q.push_back(8'hF0);
        wait_req("ackret");
        irq = 4'h0;
        int_ack = 1'b1;
        int_ret = 1'b1;
        tick();
        int_ack = 1'b0;
        int_ret = 1'b0;
        check("ackret_isr",  {28'b0, in_service}, 32'h1);
        check("ackret_pend", {28'b0, pending}, 32'h4);
        exp_q.push_back(8'hF8);
        pulse_ret();
        wait_req("resume2");
        pulse_ack();
        pulse_ret();
        check("idle_isr", {28'b0, in_service}, 32'h0);
        pulse_ret();
        check("ret_empty", {28'b0, in_service}, 32'h0);
        check("ret_empty_req", {31'b0, int_req}, 32'd0);

        // Ack in IDLE is ignored.
        pulse_ack();
        check("ack_idle_isr", {28'b0, in_service}, 32'h0);

        // Reset during REQ, then release with all lines held high.
        irq = 4'b0010;
        exp_q.push_back(8'hF4);
        wait_req("prerst");
        reset = 1'b0;
        #1;
        check("arst_req",  {31'b0, int_req}, 32'd0);
        check("arst_vec",  {24'b0, int_vec}, 32'hF0);
        check("arst_pend", {28'b0, pending}, 32'h0);
        check("arst_mask", {28'b0, mask}, 32'h0);
        irq = 4'hF;
        repeat (2) tick();
        reset = 1'b1;
        set_mask(4'hF);
        repeat (10) tick();
        check("rel_pend", {28'b0, pending}, 32'h0);
        check("rel_req",  {31'b0, int_req}, 32'd0);
        check("sb_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter: VEC_BASE, default 8'hF0, base address of the interrupt vector table.
REQ-003 clk  input  1  rising-edge system clock.
REQ-004 reset  input  1  asynchronous reset, active-low.
REQ-005 irq  input  4  external interrupt lines; asynchronous, level, rising edge significant.
REQ-006 mask_we  input  1  write enable for the mask register.
REQ-007 mask_in  input  4  new mask value; 1 = source enabled.
REQ-008 int_ack  input  1  one-cycle pulse from the control unit: interrupt entered, return address saved.
REQ-009 int_ret  input  1  one-cycle pulse from the control unit: return-from-interrupt executed.
REQ-010 int_req  output  1  interrupt request to the control unit.
REQ-011 int_vec  output  8  handler address for the granted source.
REQ-012 pending  output  4  latched, not yet acknowledged requests.
REQ-013 in_service  output  4  sources whose handlers are active (nesting allowed).
REQ-014 mask  output  4  current mask register.

Function
REQ-015 Each irq bit SHALL pass a 2-flop synchronizer; a 0->1 transition of the synchronized level SHALL set that pending bit one cycle later. Edge-to-pending latency: 3 clk.
REQ-016 Priority SHALL be fixed: irq[0] highest, irq[3] lowest.
REQ-017 Source n is eligible when pending[n] & mask[n], and n has higher priority than every set in_service bit.
REQ-018 FSM states: IDLE, REQ.
REQ-019 IDLE->REQ on the first cycle any source is eligible: latch the highest-priority eligible index as grant.
REQ-020 int_req = 1 exactly in REQ; int_vec = VEC_BASE + 4*grant in REQ, VEC_BASE in IDLE.
REQ-021 In REQ, grant and int_vec SHALL stay stable until int_ack, even if mask or pending change. No retraction.
REQ-022 REQ->IDLE on int_ack: clear pending[grant], set in_service[grant]. int_req is low the following cycle.
REQ-023 int_ack in IDLE SHALL be ignored.
REQ-024 int_ret SHALL clear the highest-priority set in_service bit. int_ret with in_service = 0 SHALL be ignored.
REQ-025 int_ack and int_ret in the same cycle: evaluate int_ret on the old in_service, then set in_service[grant].
REQ-026 A new edge on source n in the same cycle int_ack clears pending[n]: set SHALL win (pending[n] stays 1).
REQ-027 Edges while pending[n] = 1 SHALL be absorbed (no counting).
REQ-028 mask_we SHALL update mask on the next edge. Masked sources still latch pending.
REQ-029 A re-entry to REQ SHALL occur no earlier than one cycle after int_ack (minimum 1 IDLE cycle).

Reset
REQ-030 While reset = 0: state = IDLE, pending = 0, in_service = 0, mask = 4'h0, synchronizers = 0, int_req = 0, int_vec = VEC_BASE. These values SHALL take effect asynchronously.
REQ-031 Reset asserted mid-REQ SHALL drop int_req immediately. After release, no request is raised unless a fresh rising edge is synchronized.
REQ-032 An irq line held high through reset release SHALL NOT set pending.

Verification
REQ-033 Basic: mask = 4'hF, pulse irq[2] -> pending = 4'b0100 after 3 clk. int_req = 1 with int_vec = 8'hF8. int_ack -> pending = 0, in_service = 4'b0100, int_req = 0.
REQ-034 Priority: irq[3] and irq[1] rise together, mask = 4'hF -> int_vec = 8'hF4 first. After ack, irq[3] is blocked (not higher than 1). int_ret -> int_vec = 8'hFC.
REQ-035 Nesting: in_service = 4'b1000, irq[0] rises -> int_req with int_vec = 8'hF0. After ack, in_service = 4'b1001. Two int_ret -> 4'b1000, then 4'b0000.
REQ-036 Mask: mask = 4'h0, irq[1] rises -> pending = 4'b0010, int_req = 0. Write mask = 4'h2 -> int_req rises the cycle after the mask update.
REQ-037 Boundaries: same-cycle int_ack plus a new irq[grant] edge -> pending bit stays 1. Same-cycle ack/ret follows REQ-025. int_ret with in_service = 0 -> no change.
REQ-038 Reset: assert reset low during REQ -> int_req = 0 immediately with all registers cleared. Release with irq = 4'hF held -> int_req stays 0.
